// File: rtl/myip_v1_0.sv
`default_nettype none
// ============================================================================
//  Module      : myip_v1_0
//  Description : AXI4-Stream MLP coprocessor (7 features, 2 hidden, 1 output)
//                over a 64-row frame, computed with one sequential MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module myip_v1_0 #(
  parameter int NUM_ROWS = 64,
  parameter int NUM_FEAT = 7
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);

  localparam int c_num_hid       = 2;
  localparam int c_hw_base       = NUM_ROWS * NUM_FEAT;
  localparam int c_ow_base       = c_hw_base + c_num_hid * (NUM_FEAT + 1);
  localparam int c_num_in_words  = c_ow_base + c_num_hid + 1;
  localparam int c_num_out_words = 2 * NUM_ROWS;
  localparam int c_last_step     = 2 * NUM_FEAT + 1;
  localparam int IW              = $clog2(c_num_in_words);
  localparam int RW              = $clog2(NUM_ROWS);
  localparam int OW              = $clog2(c_num_out_words);
  localparam int SW              = $clog2(c_last_step + 1);

  typedef enum logic [1:0] {
    ST_READ    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_mem [c_num_in_words];
  logic [7:0]      r_y   [NUM_ROWS];
  logic [IW-1:0]   r_in_cnt;
  logic [RW-1:0]   r_row;
  logic [SW-1:0]   r_step;
  logic [19:0]     r_acc;
  logic [7:0]      r_h0, r_h1;
  logic [OW-1:0]   r_out_idx;
  logic            r_tvalid, r_tlast;
  logic [7:0]      r_tdata;

  logic            w_accept, w_last_in, w_mac_end, w_last_mac, w_out_hs, w_last_out;
  logic [SW-1:0]   w_k;
  logic [IW-1:0]   w_row_base, w_hw_off;
  logic            w_first;
  logic [7:0]      w_a, w_b, w_bias, w_sat, w_y_next, w_word_next, w_word_first;
  logic [15:0]     w_prod;
  logic [19:0]     w_sum;
  logic [OW-1:0]   w_next_idx;
  logic            w_unused;

  assign w_unused   = ^{S_AXIS_TDATA[31:8], S_AXIS_TLAST};
  assign w_accept   = S_AXIS_TVALID && (r_state == ST_READ);
  assign w_last_in  = w_accept && (r_in_cnt == IW'(c_num_in_words - 1));
  assign w_mac_end  = (r_state == ST_COMPUTE) && (r_step == SW'(c_last_step));
  assign w_last_mac = w_mac_end && (r_row == RW'(NUM_ROWS - 1));
  assign w_out_hs   = r_tvalid && M_AXIS_TREADY;
  assign w_last_out = w_out_hs && (r_out_idx == OW'(c_num_out_words - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_READ;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    S_AXIS_TREADY = 1'b0;
    case (r_state)
      ST_READ: begin
        S_AXIS_TREADY = 1'b1;
        if (w_last_in) w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: if (w_last_mac) w_state_nxt = ST_WRITE;
      ST_WRITE:   if (w_last_out) w_state_nxt = ST_READ;
      default:    w_state_nxt = ST_READ;
    endcase
  end

  // Per row: steps 0..13 are the two hidden dot products, 14..15 the output neuron.
  assign w_row_base = IW'(r_row) * IW'(NUM_FEAT);

  always_comb begin
    w_k      = '0;
    w_hw_off = '0;
    w_first  = 1'b0;
    w_a      = '0;
    w_b      = '0;
    w_bias   = '0;
    if (r_step < SW'(NUM_FEAT)) begin
      w_k     = r_step;
      w_first = (r_step == '0);
    end else if (r_step < SW'(2 * NUM_FEAT)) begin
      w_k      = r_step - SW'(NUM_FEAT);
      w_hw_off = IW'(NUM_FEAT + 1);
      w_first  = (r_step == SW'(NUM_FEAT));
    end
    if (r_step < SW'(2 * NUM_FEAT)) begin
      w_a    = r_mem[w_row_base + IW'(w_k)];
      w_b    = r_mem[IW'(c_hw_base) + w_hw_off + IW'(w_k) + IW'(1)];
      w_bias = r_mem[IW'(c_hw_base) + w_hw_off];
    end else if (r_step == SW'(2 * NUM_FEAT)) begin
      w_a     = r_h0;
      w_b     = r_mem[IW'(c_ow_base + 1)];
      w_bias  = r_mem[IW'(c_ow_base)];
      w_first = 1'b1;
    end else begin
      w_a = r_h1;
      w_b = r_mem[IW'(c_ow_base + 2)];
    end
  end

  assign w_prod = w_a * w_b;
  assign w_sum  = (w_first ? {4'd0, w_bias, 8'd0} : r_acc) + {4'd0, w_prod};
  assign w_sat  = (|w_sum[19:16]) ? 8'hFF : w_sum[15:8];

  // Odd output words carry the class flag (MSB of Y), even words carry Y itself.
  assign w_next_idx   = r_out_idx + OW'(1);
  assign w_y_next     = r_y[w_next_idx[OW-1:1]];
  assign w_word_next  = w_next_idx[0] ? {7'd0, w_y_next[7]} : w_y_next;
  assign w_word_first = r_y[0];

  always_ff @(posedge ACLK) begin
    if (w_accept)  r_mem[r_in_cnt] <= S_AXIS_TDATA[7:0];
    if (w_mac_end) r_y[r_row]      <= w_sat;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_in_cnt  <= '0;
      r_row     <= '0;
      r_step    <= '0;
      r_acc     <= '0;
      r_h0      <= '0;
      r_h1      <= '0;
      r_out_idx <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
    end else begin
      if (w_accept) r_in_cnt <= w_last_in ? '0 : r_in_cnt + IW'(1);
      if (r_state == ST_COMPUTE) begin
        r_acc <= w_sum;
        if (r_step == SW'(NUM_FEAT - 1))     r_h0 <= w_sat;
        if (r_step == SW'(2 * NUM_FEAT - 1)) r_h1 <= w_sat;
        if (w_mac_end) begin
          r_step <= '0;
          r_row  <= w_last_mac ? '0 : r_row + RW'(1);
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
      if (w_last_mac) begin
        r_tvalid  <= 1'b1;
        r_tlast   <= 1'b0;
        r_tdata   <= w_word_first;
        r_out_idx <= '0;
      end else if (w_out_hs) begin
        if (w_last_out) begin
          r_tvalid  <= 1'b0;
          r_tlast   <= 1'b0;
          r_out_idx <= '0;
        end else begin
          r_out_idx <= w_next_idx;
          r_tdata   <= w_word_next;
          r_tlast   <= (w_next_idx == OW'(c_num_out_words - 1));
        end
      end
    end
  end

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TDATA  = {24'd0, r_tdata};

endmodule
`default_nettype wire

// File: tb/tb_myip_v1_0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_myip_v1_0
//  Description : Randomized self-checking bench for myip_v1_0 with a
//                behavioural MLP model and an in-order output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_myip_v1_0;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;

  myip_v1_0 dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  frame [467];
  logic [32:0] exp_q [$];
  int          frames_done = 0;
  int          out_idx = 0;
  int          drop_cnt = 0;
  bit          drop_after4 = 1'b0;
  bit          rand_ready = 1'b0;
  bit          rand_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference MLP for one row of the current frame buffer.
  function automatic int row_y(input int r);
    int hacc, yacc, y;
    int h [2];
    for (int j = 0; j < 2; j++) begin
      hacc = int'(frame[448 + 8*j]) * 256;
      for (int k = 0; k < 7; k++)
        hacc += int'(frame[r*7 + k]) * int'(frame[449 + 8*j + k]);
      h[j] = (hacc / 256 > 255) ? 255 : hacc / 256;
    end
    yacc = int'(frame[464]) * 256 + h[0] * int'(frame[465]) + h[1] * int'(frame[466]);
    y = yacc / 256;
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic push_expect();
    int y;
    for (int r = 0; r < 64; r++) begin
      y = row_y(r);
      exp_q.push_back({1'b0, 32'(y)});
      exp_q.push_back({(r == 63), 32'(y >= 128)});
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 467; i++) frame[i] = 8'($urandom);
  endtask

  task automatic send_word(input logic [7:0] d, input bit last);
    int  t = 0;
    bit  rdy;
    if (rand_valid)
      while ($urandom_range(1, 0) == 0) begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = $urandom;
        @(posedge ACLK); #1;
      end
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = {24'($urandom), d};
    S_AXIS_TLAST  = last;
    forever begin
      @(negedge ACLK);
      rdy = S_AXIS_TREADY;
      @(posedge ACLK); #1;
      if (rdy) break;
      if (++t > 5000) begin
        check("input_accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic send_frame(input int n_words);
    for (int i = 0; i < n_words; i++) send_word(frame[i], i == 466);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (frames_done < target && t < 10000) begin
      @(posedge ACLK);
      t++;
    end
    #1;
    check("frames_done", 32'(frames_done), 32'(target));
  endtask

  always @(posedge ACLK) begin
    #1;
    if (drop_cnt > 0) begin
      M_AXIS_TREADY = 1'b0;
      drop_cnt--;
    end else begin
      M_AXIS_TREADY = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
  end

  // Compare process: sampled on the falling edge, ahead of the next rising edge.
  bit          stall = 1'b0, prev_valid = 1'b0, check_rdy = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  int          lat = 0;
  logic [32:0] e;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      check("tvalid_in_reset", 32'(M_AXIS_TVALID), 32'd0);
      stall = 1'b0; prev_valid = 1'b0; check_rdy = 1'b0; lat = 0; out_idx = 0;
    end else begin
      if (check_rdy) begin
        check("tready_after_tlast", 32'(S_AXIS_TREADY), 32'd1);
        check_rdy = 1'b0;
      end
      if (stall) begin
        check("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
        check("hold_data", M_AXIS_TDATA, hold_data);
        check("hold_last", 32'(M_AXIS_TLAST), 32'(hold_last));
      end
      if (M_AXIS_TVALID && !prev_valid) begin
        n_checks++;
        if (lat == 0 || lat > 2000) begin
          n_errors++;
          $display("FAIL compute_latency: got %0d cycles expected 1..2000", lat);
        end
      end
      if (M_AXIS_TVALID) check("tready_low_in_write", 32'(S_AXIS_TREADY), 32'd0);
      lat = (!S_AXIS_TREADY && !M_AXIS_TVALID) ? lat + 1 : 0;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_word", M_AXIS_TDATA, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", M_AXIS_TDATA, e[31:0]);
          check("out_last", 32'(M_AXIS_TLAST), 32'(e[32]));
        end
        if (drop_after4 && out_idx == 4) drop_cnt = 3;
        if (out_idx == 127) begin
          out_idx = 0;
          frames_done++;
          check_rdy = 1'b1;
        end else begin
          out_idx++;
        end
      end
      stall      = M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_data  = M_AXIS_TDATA;
      hold_last  = M_AXIS_TLAST;
      prev_valid = M_AXIS_TVALID;
    end
  end

  initial begin
    #900000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    check("rst_tdata", M_AXIS_TDATA, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("tready_after_reset", 32'(S_AXIS_TREADY), 32'd1);
    @(posedge ACLK); #1;

    // Zero inputs: only biases reach the output.
    for (int i = 0; i < 448; i++) frame[i] = 8'd0;
    for (int j = 0; j < 2; j++) begin
      frame[448 + 8*j] = 8'd5;
      for (int k = 0; k < 7; k++) frame[449 + 8*j + k] = 8'($urandom);
    end
    frame[464] = 8'd10; frame[465] = 8'hFF; frame[466] = 8'hFF;
    check("model_pin_bias_only", 32'(row_y(0)), 32'd19);
    send_frame(467); push_expect(); wait_done(1);

    // Saturating hidden layer.
    for (int i = 0; i < 448; i++) frame[i] = 8'd255;
    for (int j = 0; j < 2; j++) begin
      frame[448 + 8*j] = 8'd0;
      for (int k = 0; k < 7; k++) frame[449 + 8*j + k] = 8'd255;
    end
    frame[464] = 8'd0; frame[465] = 8'd128; frame[466] = 8'd128;
    check("model_pin_saturate", 32'(row_y(17)), 32'd255);
    send_frame(467); push_expect(); wait_done(2);

    // Random frame with downstream stall after word 4.
    randomize_frame();
    drop_after4 = 1'b1;
    send_frame(467); push_expect(); wait_done(3);
    drop_after4 = 1'b0;

    // Same frame, input valid toggled randomly.
    rand_valid = 1'b1;
    send_frame(467); push_expect(); wait_done(4);
    rand_valid = 1'b0;

    // Two frames back-to-back, random downstream ready.
    rand_ready = 1'b1;
    randomize_frame();
    send_frame(467); push_expect();
    randomize_frame();
    send_frame(467); push_expect();
    wait_done(6);
    rand_ready = 1'b0;

    // Reset after a partial frame, then a complete frame.
    randomize_frame();
    send_frame(200);
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    randomize_frame();
    send_frame(467); push_expect(); wait_done(7);

    repeat (5) @(posedge ACLK);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
